dmac_req_arbiter: RTL and testbench

DMAC_REQ_ARBITER -- requirements
Module: dmac_req_arbiter

---
 rtl/dmac_pkg.sv | 13 +
 rtl/dmac_rr_picker.sv | 30 +++
 rtl/dmac_req_arbiter.sv | 167 ++++++++++++++++
 tb/tb_dmac_req_arbiter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmac_pkg.sv
// Shared types and constants for the DMA request arbiter.
package dmac_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACK    = 2'd1,
      ST_ACTIVE = 2'd2
   } arb_state_t;

   localparam int PRIO_FIXED = 0;
   localparam int PRIO_RR    = 1;

endpackage

// File: rtl/dmac_rr_picker.sv
// Combinational winner search: first eligible channel at or after start_idx, wrapping.
module dmac_rr_picker #(
   parameter int NUM_CH = 4
) (
   input  logic [NUM_CH-1:0]         elig,
   input  logic [$clog2(NUM_CH)-1:0] start_idx,
   output logic [$clog2(NUM_CH)-1:0] pick_idx,
   output logic                      pick_vld
);

   localparam int IDX_W = $clog2(NUM_CH);

   always_comb begin
      int pos;
      pos      = 0;
      pick_idx = '0;
      pick_vld = 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
         pos = int'(start_idx) + k;
         if (pos >= NUM_CH) begin
            pos = pos - NUM_CH;
         end
         if (!pick_vld && elig[pos]) begin
            pick_vld = 1'b1;
            pick_idx = IDX_W'(pos);
         end
      end
   end

endmodule

// File: rtl/dmac_req_arbiter.sv
// Peripheral DMA request arbiter: latches requests, grants one channel with a
// registered ReqAck handshake, tracks the transfer and records per-channel errors.
module dmac_req_arbiter
   import dmac_pkg::*;
#(
   parameter int NUM_CH      = 4,
   parameter int PRIO_MODE   = PRIO_FIXED,
   parameter int ACK_TIMEOUT = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_CH-1:0]         DmacReq,
   input  logic [NUM_CH-1:0]         Ch_En,
   input  logic                      Xfer_Done,
   input  logic                      Xfer_Err,
   input  logic [NUM_CH-1:0]         Err_Clr,
   output logic [NUM_CH-1:0]         ReqAck,
   output logic [$clog2(NUM_CH)-1:0] Ch_Sel,
   output logic                      Ch_Start,
   output logic                      Busy,
   output logic [NUM_CH-1:0]         Err_Status
);

   localparam int               IDX_W   = $clog2(NUM_CH);
   localparam int               CNT_W   = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
   localparam logic [CNT_W:0]   TO_LIM  = (CNT_W + 1)'(ACK_TIMEOUT);
   localparam logic [IDX_W-1:0] LAST_CH = IDX_W'(NUM_CH - 1);

   arb_state_t        state_q, state_d;
   logic [NUM_CH-1:0] req_q, req_d;
   logic [NUM_CH-1:0] ack_q, ack_d;
   logic [NUM_CH-1:0] err_q, err_d;
   logic [IDX_W-1:0]  sel_q, sel_d;
   logic [IDX_W-1:0]  last_q, last_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              start_q, start_d;

   logic [NUM_CH-1:0] elig;
   logic [NUM_CH-1:0] pick_mask;
   logic [IDX_W-1:0]  pick_start;
   logic [IDX_W-1:0]  pick_idx;
   logic              pick_vld;
   logic [IDX_W-1:0]  win_idx;
   logic [NUM_CH-1:0] req_clr;
   logic [NUM_CH-1:0] err_set;
   logic [CNT_W:0]    cnt_inc;
   logic              timeout_hit;

   // Fixed priority reuses the wrap-around search on a bit-reversed mask from
   // index 0, so the lowest reversed hit is the highest original index.
   always_comb begin
      elig       = req_q & Ch_En;
      pick_mask  = elig;
      pick_start = (last_q == LAST_CH) ? '0 : last_q + 1'b1;
      if (PRIO_MODE == PRIO_FIXED) begin
         pick_start = '0;
         for (int i = 0; i < NUM_CH; i++) begin
            pick_mask[i] = elig[NUM_CH-1-i];
         end
      end
   end

   dmac_rr_picker #(
      .NUM_CH (NUM_CH)
   ) u_picker (
      .elig      (pick_mask),
      .start_idx (pick_start),
      .pick_idx  (pick_idx),
      .pick_vld  (pick_vld)
   );

   always_comb begin
      win_idx = pick_idx;
      if (PRIO_MODE == PRIO_FIXED) begin
         win_idx = IDX_W'(NUM_CH - 1 - int'(pick_idx));
      end
   end

   assign cnt_inc     = {1'b0, cnt_q} + 1'b1;
   assign timeout_hit = (ACK_TIMEOUT != 0) && (cnt_inc == TO_LIM);

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      ack_d   = ack_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      start_d = 1'b0;
      req_clr = '0;
      err_set = '0;
      case (state_q)
         ST_IDLE: begin
            ack_d = '0;
            if (pick_vld) begin
               sel_d          = win_idx;
               ack_d[win_idx] = 1'b1;
               cnt_d          = '0;
               state_d        = ST_ACK;
            end
         end
         ST_ACK: begin
            // A dropped request takes precedence over a timeout in the same cycle.
            if (!DmacReq[sel_q]) begin
               ack_d          = '0;
               req_clr[sel_q] = 1'b1;
               start_d        = 1'b1;
               state_d        = ST_ACTIVE;
            end else if (timeout_hit) begin
               ack_d          = '0;
               req_clr[sel_q] = 1'b1;
               err_set[sel_q] = 1'b1;
               state_d        = ST_IDLE;
               if (PRIO_MODE == PRIO_RR) begin
                  last_d = sel_q;
               end
            end else if (ACK_TIMEOUT != 0) begin
               cnt_d = cnt_inc[CNT_W-1:0];
            end
         end
         ST_ACTIVE: begin
            if (Xfer_Done || Xfer_Err) begin
               err_set[sel_q] = Xfer_Err;
               state_d        = ST_IDLE;
               if (PRIO_MODE == PRIO_RR) begin
                  last_d = sel_q;
               end
            end
         end
         default: begin
            ack_d   = '0;
            state_d = ST_IDLE;
         end
      endcase
      // Clearing the granted channel wins over a still-high request in that cycle.
      req_d = (req_q | DmacReq) & ~req_clr;
      err_d = (err_q & ~Err_Clr) | err_set;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         req_q   <= '0;
         ack_q   <= '0;
         err_q   <= '0;
         sel_q   <= '0;
         last_q  <= LAST_CH;
         cnt_q   <= '0;
         start_q <= 1'b0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         sel_q   <= sel_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         start_q <= start_d;
      end
   end

   assign ReqAck     = ack_q;
   assign Ch_Sel     = sel_q;
   assign Ch_Start   = start_q;
   assign Busy       = (state_q != ST_IDLE);
   assign Err_Status = err_q;

endmodule

// File: tb/tb_dmac_req_arbiter.sv
// Directed and randomized checks of dmac_req_arbiter in fixed and round-robin configurations.
module tb_dmac_req_arbiter;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   // Two-channel fixed-priority instance
   logic       a_rst = 1'b0;
   logic [1:0] a_req = '0, a_en = 2'b11, a_clr = '0;
   logic       a_done = 1'b0, a_err = 1'b0;
   logic [1:0] a_ack, a_errst;
   logic       a_sel, a_start, a_busy;

   // Four-channel round-robin instance with a short ack timeout
   logic       b_rst = 1'b0;
   logic [3:0] b_req = '0, b_en = 4'hF, b_clr = '0;
   logic       b_done = 1'b0, b_err = 1'b0;
   logic [3:0] b_ack, b_errst;
   logic [1:0] b_sel;
   logic       b_start, b_busy;

   dmac_req_arbiter #(.NUM_CH(2), .PRIO_MODE(0), .ACK_TIMEOUT(16)) u_dut_a (
      .clk(clk), .rst(a_rst), .DmacReq(a_req), .Ch_En(a_en), .Xfer_Done(a_done),
      .Xfer_Err(a_err), .Err_Clr(a_clr), .ReqAck(a_ack), .Ch_Sel(a_sel),
      .Ch_Start(a_start), .Busy(a_busy), .Err_Status(a_errst));

   dmac_req_arbiter #(.NUM_CH(4), .PRIO_MODE(1), .ACK_TIMEOUT(4)) u_dut_b (
      .clk(clk), .rst(b_rst), .DmacReq(b_req), .Ch_En(b_en), .Xfer_Done(b_done),
      .Xfer_Err(b_err), .Err_Clr(b_clr), .ReqAck(b_ack), .Ch_Sel(b_sel),
      .Ch_Start(b_start), .Busy(b_busy), .Err_Status(b_errst));

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic b_wait_ack(output int w);
      w = -1;
      for (int i = 0; i < 20; i++) begin
         step();
         if (b_ack != 4'h0) begin
            for (int c = 0; c < 4; c++) if (b_ack[c]) w = c;
            break;
         end
      end
      if (w < 0) begin
         n_cmp++;
         n_bad++;
         $error("FAIL wait_ack: observed no grant within 20 cycles, expected a grant");
         w = 0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int         w, exp_w, d, n;
      bit         e;
      int         mlast;
      logic [3:0] mp, merr, r;

      // Reset state
      step();
      step();
      chk("a_rst_ack", a_ack, 0);
      chk("a_rst_busy", a_busy, 0);
      chk("b_rst_ack", b_ack, 0);
      chk("b_rst_sel", b_sel, 0);
      chk("b_rst_start", b_start, 0);
      chk("b_rst_err", b_errst, 0);
      a_rst = 1'b1;
      b_rst = 1'b1;
      step();

      // Fixed priority, both channels requesting
      a_req = 2'b11;
      step();
      chk("a_no_early_ack", a_ack, 0);
      step();
      chk("a_ack_hi", a_ack, 2'b10);
      chk("a_sel_hi", a_sel, 1);
      chk("a_busy_ack", a_busy, 1);
      a_req = 2'b01;
      step();
      chk("a_start", a_start, 1);
      chk("a_start_sel", a_sel, 1);
      chk("a_ack_clr", a_ack, 0);
      step();
      chk("a_start_pulse", a_start, 0);
      a_done = 1'b1;
      step();
      a_done = 1'b0;
      chk("a_idle_gap_busy", a_busy, 0);
      chk("a_idle_gap_ack", a_ack, 0);
      step();
      chk("a_ack_lo", a_ack, 2'b01);
      chk("a_sel_lo", a_sel, 0);
      a_req = 2'b00;
      step();
      chk("a_start_lo", a_start, 1);
      step();
      a_done = 1'b1;
      step();
      a_done = 1'b0;
      chk("a_final_idle", a_busy, 0);

      // Round-robin order with all channels requesting
      b_req = 4'hF;
      for (int g = 0; g < 5; g++) begin
         b_wait_ack(w);
         chk("rr_order", w, g % 4);
         b_req[w] = 1'b0;
         step();
         chk("rr_start", b_start, 1);
         chk("rr_sel", b_sel, g % 4);
         if (g == 0) b_req[0] = 1'b1;
         step();
         b_done = 1'b1;
         step();
         b_done = 1'b0;
         chk("rr_idle", b_busy, 0);
      end
      b_req = 4'h0;

      // Ack timeout on channel 2
      b_req = 4'b0100;
      step();
      step();
      for (int i = 0; i < 4; i++) begin
         chk("to_ack_held", b_ack, 4'b0100);
         chk("to_no_start", b_start, 0);
         if (i < 3) step();
      end
      step();
      chk("to_ack_drop", b_ack, 0);
      chk("to_err_set", b_errst, 4'b0100);
      chk("to_no_start_end", b_start, 0);
      chk("to_busy", b_busy, 0);
      b_req = 4'h0;
      step();
      chk("to_stay_idle", b_busy, 0);
      b_clr = 4'b0100;
      step();
      b_clr = 4'h0;
      chk("to_err_clr", b_errst, 0);

      // Disabled channel keeps its pending request
      b_en  = 4'b1101;
      b_req = 4'b0010;
      step();
      b_req = 4'h0;
      step();
      chk("en_masked_ack", b_ack, 0);
      step();
      chk("en_masked_ack2", b_ack, 0);
      chk("en_masked_busy", b_busy, 0);
      b_en = 4'hF;
      step();
      chk("en_ack", b_ack, 4'b0010);
      chk("en_sel", b_sel, 1);
      step();
      chk("en_start", b_start, 1);

      // Asynchronous reset while ACTIVE
      #2;
      b_rst = 1'b0;
      #1;
      chk("rst_ack", b_ack, 0);
      chk("rst_sel", b_sel, 0);
      chk("rst_start", b_start, 0);
      chk("rst_busy", b_busy, 0);
      chk("rst_err", b_errst, 0);
      step();
      b_rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("post_rst_busy", b_busy, 0);
         chk("post_rst_ack", b_ack, 0);
      end

      // Transfer error on channel 3, with a simultaneous clear of the same bit
      b_req = 4'b1000;
      step();
      step();
      chk("xe_ack", b_ack, 4'b1000);
      b_req = 4'h0;
      step();
      chk("xe_start", b_start, 1);
      b_err = 1'b1;
      b_clr = 4'b1000;
      step();
      b_err = 1'b0;
      b_clr = 4'h0;
      chk("xe_err_set", b_errst, 4'b1000);
      chk("xe_idle", b_busy, 0);
      b_done = 1'b1;
      step();
      b_done = 1'b0;
      chk("done_idle_busy", b_busy, 0);
      step();
      chk("done_idle_busy2", b_busy, 0);
      chk("done_idle_ack", b_ack, 0);
      chk("done_idle_err", b_errst, 4'b1000);
      b_clr = 4'b1000;
      step();
      b_clr = 4'h0;
      chk("xe_err_clr", b_errst, 0);

      // Randomized traffic against a round-robin reference model
      mlast = 3;
      merr  = 4'h0;
      mp    = 4'h0;
      for (int t = 0; t < 30; t++) begin
         if (mp == 4'h0) begin
            r     = 4'($urandom_range(1, 15));
            mp    = mp | r;
            b_req = b_req | r;
         end
         b_wait_ack(w);
         exp_w = -1;
         for (int k = 1; k <= 4; k++) begin
            if (exp_w < 0 && mp[(mlast + k) % 4]) exp_w = (mlast + k) % 4;
         end
         chk("rand_grant", b_ack, 1 << exp_w);
         chk("rand_sel", b_sel, exp_w);
         d = $urandom_range(0, 2);
         for (int i = 0; i < d; i++) begin
            step();
            chk("rand_hold", b_ack, 1 << exp_w);
         end
         b_req[w] = 1'b0;
         step();
         chk("rand_start", b_start, 1);
         chk("rand_ack_clr", b_ack, 0);
         mp[w] = 1'b0;
         r     = 4'($urandom) & ~b_req;
         b_req = b_req | r;
         mp    = mp | r;
         n = $urandom_range(1, 3);
         for (int i = 0; i < n; i++) step();
         e = ($urandom_range(0, 3) == 0);
         if (e) b_err = 1'b1;
         else   b_done = 1'b1;
         step();
         b_err  = 1'b0;
         b_done = 1'b0;
         mlast = w;
         if (e) merr[w] = 1'b1;
         chk("rand_err", b_errst, merr);
         chk("rand_idle", b_busy, 0);
      end

      b_req = 4'h0;
      b_clr = 4'hF;
      step();
      b_clr = 4'h0;
      chk("final_err_clr", b_errst, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
